// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter slice: opcodes, flag bit positions, FSM states.
// No logic; imported by the ALU, the picker's users and the arbiter top.
// Optional feature macro used elsewhere in the slice: ALU_ARB_LOCK_EN.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    AND  = 3'b010,
    OR   = 3'b011,
    XOR  = 3'b100,
    NOTA = 3'b101,
    NOTB = 3'b110,
    ZERO = 3'b111
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the issue agents and the shared ALU arbiter.
// master = requester/consumer side, slave = arbiter side.
// req_lock exists only when ALU_ARB_LOCK_EN is defined.
interface alu_arbiter_if #(
  parameter int M = 4,
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]                  req_valid;
  logic [N-1:0]                  req_ready;
  logic [N-1:0][M-1:0]           req_a;
  logic [N-1:0][M-1:0]           req_b;
  alu_pkg::alu_op_t [N-1:0]      req_op;
  logic                          resp_valid;
  logic [IW-1:0]                 resp_id;
  logic [M-1:0]                  resp_y;
  logic [3:0]                    resp_flags;
  logic                          resp_ready;
`ifdef ALU_ARB_LOCK_EN
  logic [N-1:0]                  req_lock;

  modport master (
    output req_valid, req_a, req_b, req_op, req_lock, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_y, resp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_lock, resp_ready,
    output req_ready, resp_valid, resp_id, resp_y, resp_flags
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_y, resp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_id, resp_y, resp_flags
  );
`endif

endinterface

// File: rtl/alu.sv
// M-bit combinational ALU producing result and {N,Z,C,V} flags.
// Zero latency; no handshake, the caller registers inputs and outputs.
module alu
  import alu_pkg::*;
#(
  parameter int M = 4
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  alu_op_t      op,
  output logic [M-1:0] y,
  output logic [3:0]   flags
);

  logic [M-1:0] b_eff;
  logic [M:0]   sum;
  logic         c;
  logic         v;

  // SUB reuses the adder as A + ~B + 1; C/V come only from ADD/SUB.
  always_comb begin
    b_eff = (op == SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{M{1'b0}}, (op == SUB)};
    y     = '0;
    c     = 1'b0;
    v     = 1'b0;
    case (op)
      ADD, SUB: begin
        y = sum[M-1:0];
        c = sum[M];
        v = (a[M-1] == b_eff[M-1]) && (sum[M-1] != a[M-1]);
      end
      AND:     y = a & b;
      OR:      y = a | b;
      XOR:     y = a ^ b;
      NOTA:    y = ~a;
      NOTB:    y = ~b;
      default: y = '0;
    endcase
    flags         = '0;
    flags[FLAG_N] = y[M-1];
    flags[FLAG_Z] = (y == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first valid index at or after ptr, searching upward mod N.
// Purely combinational, zero latency; no backpressure of its own.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  // Walk the rotated request vector and keep only the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!any && valid[j]) begin
        any      = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N requesters: round-robin grant, registered operands and result.
// Latency grant->resp_valid 2 cycles, 3-cycle minimum occupancy per operation.
// resp_ready low holds RESP (result, id stable) and blocks all new grants.
// With ALU_ARB_LOCK_EN defined, a locked requester keeps top priority after its response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  localparam int IW = $clog2(N);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id;
  logic [IW-1:0] id_inc;
  logic [IW-1:0] ptr_nxt;
  logic [M-1:0]  a_q;
  logic [M-1:0]  b_q;
  alu_op_t       op_q;
  logic [M-1:0]  resp_y_q;
  logic [3:0]    resp_flags_q;

  logic [N-1:0]  grant;
  logic [IW-1:0] win;
  logic          any;
  logic [M-1:0]  alu_y;
  logic [3:0]    alu_flags;

  rr_picker #(.N(N), .IW(IW)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  alu #(.M(M)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .y     (alu_y),
    .flags (alu_flags)
  );

  // Grants are only visible in IDLE and never while reset is held.
  assign bus.req_ready  = (rst_n && state == ST_IDLE) ? grant : '0;
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_id    = id;
  assign bus.resp_y     = resp_y_q;
  assign bus.resp_flags = resp_flags_q;

  // Next round-robin start point once the current response is taken.
  always_comb begin
    id_inc = (id == IW'(N - 1)) ? '0 : id + 1'b1;
`ifdef ALU_ARB_LOCK_EN
    ptr_nxt = bus.req_lock[id] ? id : id_inc;
`else
    ptr_nxt = id_inc;
`endif
  end

  // IDLE latches the winner, EXEC registers the ALU output, RESP waits for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      id           <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= ADD;
      resp_y_q     <= '0;
      resp_flags_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            a_q   <= bus.req_a[win];
            b_q   <= bus.req_b[win];
            op_q  <= bus.req_op[win];
            id    <= win;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_y_q     <= alu_y;
          resp_flags_q <= alu_flags;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            ptr   <= ptr_nxt;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single ops, round-robin order, back-pressure, reset abort.
// Lock priority sequence is exercised when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.M(4), .N(4)) bus ();

  alu_arbiter #(.M(4), .N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < 4; i++) bus.req_op[i] = ADD;
`ifdef ALU_ARB_LOCK_EN
    bus.req_lock  = '0;
`endif
  endtask

  task automatic do_reset();
    clear_reqs();
    bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // One isolated request: grant now, response exactly two cycles later.
  task automatic run_op(input int r, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic [3:0] ey, input logic [3:0] ef);
    int w;
    logic [3:0] eg;
    clear_reqs();
    bus.resp_ready = 1'b1;
    bus.req_valid[r] = 1'b1;
    bus.req_a[r] = a;
    bus.req_b[r] = b;
    bus.req_op[r] = alu_op_t'(op);
    #1;
    w = 0;
    while (bus.req_ready == '0 && w < 8) begin
      tick();
      w++;
    end
    eg = '0;
    eg[r] = 1'b1;
    check("op_grant", bus.req_ready, eg);
    tick();
    bus.req_valid[r] = 1'b0;
    check("op_exec_valid", bus.resp_valid, 0);
    tick();
    check("op_resp_valid", bus.resp_valid, 1);
    check("op_resp_id", bus.resp_id, r);
    check("op_resp_y", bus.resp_y, ey);
    check("op_resp_flags", bus.resp_flags, ef);
    tick();
  endtask

  // Directed vectors: requester, a, b, op, expected y, expected {N,Z,C,V}.
  int         v_r[7]  = '{2, 0, 1, 1, 3, 2, 0};
  logic [3:0] v_a[7]  = '{4'h7, 4'h8, 4'h3, 4'h2, 4'hA, 4'h5, 4'hF};
  logic [3:0] v_b[7]  = '{4'h1, 4'h8, 4'h3, 4'h3, 4'h6, 4'h0, 4'hF};
  logic [2:0] v_op[7] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b101, 3'b111};
  logic [3:0] v_y[7]  = '{4'h8, 4'h0, 4'h0, 4'hF, 4'hC, 4'hA, 4'h0};
  logic [3:0] v_f[7]  = '{4'b1001, 4'b0111, 4'b0110, 4'b1000, 4'b1000, 4'b1000, 4'b0100};

  initial begin
    logic [3:0] eg;
    clear_reqs();
    bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    bus.req_valid = 4'b1111;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_id", bus.resp_id, 0);
    check("rst_resp_y", bus.resp_y, 0);
    check("rst_resp_flags", bus.resp_flags, 0);
    do_reset();

    // Vector 0 is r2 from ptr 0; vector 1 is r0 with ptr=3 (wrap case).
    for (int k = 0; k < 7; k++)
      run_op(v_r[k], v_a[k], v_b[k], v_op[k], v_y[k], v_f[k]);

    // All four valid from reset: grants 0,1,2,3,0, three cycles apart.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i] = 4'(i + 1);
      bus.req_b[i] = 4'h2;
      bus.req_op[i] = ADD;
    end
    bus.req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 13; c++) begin
      eg = '0;
      if (c % 3 == 0) eg[(c / 3) % 4] = 1'b1;
      check("rr_grant", bus.req_ready, eg);
      if (c % 3 == 2) begin
        check("rr_resp_id", bus.resp_id, (c / 3) % 4);
        check("rr_resp_y", bus.resp_y, ((c / 3) % 4) + 3);
      end
      tick();
    end

    // Back-pressure: r3 result held for 5 cycles while r0/r1 wait.
    do_reset();
    bus.resp_ready = 1'b0;
    bus.req_valid[3] = 1'b1;
    bus.req_a[3] = 4'h5;
    bus.req_b[3] = 4'h2;
    bus.req_op[3] = ADD;
    #1;
    check("bp_grant", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = 4'b0011;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_resp_valid", bus.resp_valid, 1);
      check("bp_resp_y", bus.resp_y, 4'h7);
      check("bp_resp_id", bus.resp_id, 3);
      check("bp_no_grant", bus.req_ready, 0);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    check("bp_resp_done", bus.resp_valid, 0);
    check("bp_next_grant", bus.req_ready, 4'b0001);

    // Reset during EXEC aborts the r0 operation; resp_y still holds the old 7 until then.
    tick();
    bus.req_valid = '0;
    check("rx_in_exec_y", bus.resp_y, 4'h7);
    rst_n = 1'b0;
    #1;
    check("rx_resp_valid", bus.resp_valid, 0);
    check("rx_resp_y", bus.resp_y, 0);
    check("rx_resp_id", bus.resp_id, 0);
    check("rx_resp_flags", bus.resp_flags, 0);
    check("rx_req_ready", bus.req_ready, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rx_no_resp", bus.resp_valid, 0);
    end
    bus.req_valid = 4'b0101;
    #1;
    check("rx_first_grant", bus.req_ready, 4'b0001);

`ifdef ALU_ARB_LOCK_EN
    // r1 locked: wins three times, then after unlock order is r2 then r0.
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_lock  = 4'b0010;
    #1;
    for (int c = 0; c < 13; c++) begin
      eg = '0;
      if (c == 0 || c == 3 || c == 6) eg[1] = 1'b1;
      if (c == 9) eg[2] = 1'b1;
      if (c == 12) eg[0] = 1'b1;
      check("lock_grant", bus.req_ready, eg);
      tick();
      if (c == 0) bus.req_valid = 4'b0111;
      if (c == 7) bus.req_lock = 4'b0000;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
